// File: rtl/rv32i_decode_regfile.sv
// RV32I ID stage: combinational instruction decoder driving a 32x32 register file
// (one write port from writeback, two combinational read ports for rs1/rs2).
module rv32i_decode_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [31:0] if_insn,
  input  logic [31:0] if_pc,
  output logic [4:0]  gpr_rd_addr_0,
  output logic [4:0]  gpr_rd_addr_1,
  output logic [31:0] gpr_rd_data_0,
  output logic [31:0] gpr_rd_data_1,
  output logic [4:0]  dst_addr,
  output logic        gpr_we_,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_in_0,
  output logic [31:0] alu_in_1,
  output logic [31:0] br_addr,
  output logic        br_taken,
  output logic        br_flag,
  output logic [3:0]  mem_op,
  output logic [31:0] gpr_data,
  output logic [1:0]  ctrl_op,
  output logic [2:0]  exp_code
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7,
    ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10
  } alu_e;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0, MEM_LB = 4'd1, MEM_LH = 4'd2, MEM_LW = 4'd3, MEM_LBU = 4'd4,
    MEM_LHU = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7, MEM_SW = 4'd8
  } mem_e;

  typedef enum logic [1:0] {
    CTRL_NOP = 2'd0, CTRL_ECALL = 2'd1, CTRL_EBREAK = 2'd2, CTRL_FENCE = 2'd3
  } ctrl_e;

  typedef enum logic [2:0] {
    EXP_NONE = 3'd0, EXP_ILLEGAL = 3'd1, EXP_ECALL = 3'd2, EXP_EBREAK = 3'd3
  } exp_e;

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!we_ && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign opcode = if_insn[6:0];
  assign rd     = if_insn[11:7];
  assign funct3 = if_insn[14:12];
  assign rs1    = if_insn[19:15];
  assign rs2    = if_insn[24:20];

  assign gpr_rd_addr_0 = rs1;
  assign gpr_rd_addr_1 = rs2;
  assign rs1_data      = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_data      = (rs2 == '0) ? '0 : regs[rs2];
  assign gpr_rd_data_0 = rs1_data;
  assign gpr_rd_data_1 = rs2_data;

  assign imm_i = {{20{if_insn[31]}}, if_insn[31:20]};
  assign imm_s = {{20{if_insn[31]}}, if_insn[31:25], if_insn[11:7]};
  assign imm_b = {{19{if_insn[31]}}, if_insn[31], if_insn[7], if_insn[30:25], if_insn[11:8], 1'b0};
  assign imm_u = {if_insn[31:12], 12'b0};
  assign imm_j = {{11{if_insn[31]}}, if_insn[31], if_insn[19:12], if_insn[20], if_insn[30:21], 1'b0};
  assign shamt = {27'b0, if_insn[24:20]};

  function automatic alu_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic br_cond, br_legal;

  always_comb begin
    dst_addr = '0;
    gpr_we_  = 1'b1;
    alu_op   = ALU_NOP;
    alu_in_0 = '0;
    alu_in_1 = '0;
    br_addr  = '0;
    br_taken = 1'b0;
    br_flag  = 1'b0;
    mem_op   = MEM_NOP;
    gpr_data = '0;
    ctrl_op  = CTRL_NOP;
    exp_code = EXP_NONE;
    br_cond  = 1'b0;
    br_legal = 1'b1;

    case (opcode)
      OPC_OP_IMM: begin
        dst_addr = rd;
        gpr_we_  = 1'b0;
        alu_op   = base_op(funct3);
        alu_in_0 = rs1_data;
        alu_in_1 = imm_i;
        if (funct3 == 3'b001 || funct3 == 3'b101) alu_in_1 = shamt;
        if (funct3 == 3'b101 && if_insn[30]) alu_op = ALU_SRA;
      end
      OPC_OP: begin
        dst_addr = rd;
        gpr_we_  = 1'b0;
        alu_op   = base_op(funct3);
        alu_in_0 = rs1_data;
        alu_in_1 = rs2_data;
        if (if_insn[30] && funct3 == 3'b000) alu_op = ALU_SUB;
        if (if_insn[30] && funct3 == 3'b101) alu_op = ALU_SRA;
      end
      OPC_LUI, OPC_AUIPC: begin
        dst_addr = rd;
        gpr_we_  = 1'b0;
        alu_op   = ALU_ADD;
        alu_in_0 = (opcode == OPC_AUIPC) ? if_pc : '0;
        alu_in_1 = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        if (opcode == OPC_JALR && funct3 != 3'b000) begin
          exp_code = EXP_ILLEGAL;
        end else begin
          dst_addr = rd;
          gpr_we_  = 1'b0;
          alu_op   = ALU_ADD;
          alu_in_0 = if_pc;
          alu_in_1 = 32'd4;
          br_taken = 1'b1;
          br_flag  = 1'b1;
          br_addr  = (opcode == OPC_JAL) ? (if_pc + imm_j)
                                         : ((rs1_data + imm_i) & ~32'd1);
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  br_cond = (rs1_data == rs2_data);
          3'b001:  br_cond = (rs1_data != rs2_data);
          3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
          3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  br_cond = (rs1_data <  rs2_data);
          3'b111:  br_cond = (rs1_data >= rs2_data);
          default: br_legal = 1'b0;
        endcase
        if (br_legal) begin
          br_addr  = if_pc + imm_b;
          br_flag  = 1'b1;
          br_taken = br_cond;
        end else begin
          exp_code = EXP_ILLEGAL;
        end
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            dst_addr = rd;
            gpr_we_  = 1'b0;
            alu_op   = ALU_ADD;
            alu_in_0 = rs1_data;
            alu_in_1 = imm_i;
            case (funct3)
              3'b000:  mem_op = MEM_LB;
              3'b001:  mem_op = MEM_LH;
              3'b010:  mem_op = MEM_LW;
              3'b100:  mem_op = MEM_LBU;
              default: mem_op = MEM_LHU;
            endcase
          end
          default: exp_code = EXP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: begin
            alu_op   = ALU_ADD;
            alu_in_0 = rs1_data;
            alu_in_1 = imm_s;
            gpr_data = rs2_data;
            mem_op   = (funct3 == 3'b000) ? MEM_SB : (funct3 == 3'b001) ? MEM_SH : MEM_SW;
          end
          default: exp_code = EXP_ILLEGAL;
        endcase
      end
      OPC_SYSTEM: begin
        // only the exact ECALL/EBREAK encodings are accepted; CSR forms are illegal
        if (funct3 == 3'b000 && rd == '0 && rs1 == '0 && if_insn[31:21] == '0) begin
          ctrl_op  = if_insn[20] ? CTRL_EBREAK : CTRL_ECALL;
          exp_code = if_insn[20] ? EXP_EBREAK : EXP_ECALL;
        end else begin
          exp_code = EXP_ILLEGAL;
        end
      end
      OPC_MISC_MEM: begin
        if (funct3 == 3'b000) ctrl_op  = CTRL_FENCE;
        else                  exp_code = EXP_ILLEGAL;
      end
      default: exp_code = EXP_ILLEGAL;
    endcase
  end

endmodule

// File: tb/tb_rv32i_decode_regfile.sv
// Bench for rv32i_decode_regfile: directed vector table, register-file corner
// sequences, and randomized decode checked against an arithmetic reference model.
module tb_rv32i_decode_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1, dst_addr;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        gpr_we_, br_taken, br_flag;
  logic [3:0]  alu_op, mem_op;
  logic [31:0] alu_in_0, alu_in_1, br_addr, gpr_data;
  logic [1:0]  ctrl_op;
  logic [2:0]  exp_code;

  rv32i_decode_regfile dut (
    .clk(clk), .reset(reset), .we_(we_), .wr_addr(wr_addr), .wr_data(wr_data),
    .if_insn(if_insn), .if_pc(if_pc),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .dst_addr(dst_addr), .gpr_we_(gpr_we_), .alu_op(alu_op),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .br_addr(br_addr),
    .br_taken(br_taken), .br_flag(br_flag), .mem_op(mem_op),
    .gpr_data(gpr_data), .ctrl_op(ctrl_op), .exp_code(exp_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  dst;
    logic        we;
    logic [3:0]  alu;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] bra;
    logic        bt;
    logic        bf;
    logic [3:0]  mem;
    logic [31:0] gd;
    logic [1:0]  ctrl;
    logic [2:0]  exc;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] rm [32];
  vec_t        vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] insn, input logic [31:0] pc,
                               input logic [4:0] dst, input logic we, input logic [3:0] alu,
                               input logic [31:0] in0, input logic [31:0] in1,
                               input logic [31:0] bra, input logic bt, input logic bf,
                               input logic [3:0] mem, input logic [31:0] gd,
                               input logic [1:0] ctrl, input logic [2:0] exc);
    vec_t v;
    v.insn = insn;
    v.pc   = pc;
    v.e    = '{dst, we, alu, in0, in1, bra, bt, bf, mem, gd, ctrl, exc};
    return v;
  endfunction

  // Reference decoder: immediates built by arithmetic shifts of the signed word
  function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] ii, is_, ib, iu, ij;
    logic [2:0]  f3;
    logic [3:0]  f3alu [8];
    f3alu = '{4'd1, 4'd8, 4'd3, 4'd4, 4'd5, 4'd9, 4'd6, 4'd7};
    e = '0;
    e.we = 1'b1;
    s  = insn;
    f3 = insn[14:12];
    ii  = s >>> 20;
    is_ = s >>> 25;
    is_ = (is_ << 5) | 32'(insn[11:7]);
    ib  = s >>> 31;
    ib  = (ib << 12) | (32'(insn[7]) << 11) | (32'(insn[30:25]) << 5) | (32'(insn[11:8]) << 1);
    iu  = insn & 32'hFFFFF000;
    ij  = s >>> 31;
    ij  = (ij << 20) | (32'(insn[19:12]) << 12) | (32'(insn[20]) << 11) | (32'(insn[30:21]) << 1);
    case (insn[6:0])
      7'h13, 7'h33: begin
        e.dst = insn[11:7]; e.we = 1'b0; e.in0 = a; e.alu = f3alu[f3];
        if (insn[6:0] == 7'h33) e.in1 = b;
        else if (f3 == 3'd1 || f3 == 3'd5) e.in1 = 32'(insn[24:20]);
        else e.in1 = ii;
        if (f3 == 3'd5 && insn[30]) e.alu = 4'd10;
        if (insn[6:0] == 7'h33 && f3 == 3'd0 && insn[30]) e.alu = 4'd2;
      end
      7'h37, 7'h17: begin
        e.dst = insn[11:7]; e.we = 1'b0; e.alu = 4'd1; e.in1 = iu;
        e.in0 = (insn[6:0] == 7'h17) ? pc : 32'd0;
      end
      7'h6F, 7'h67: begin
        if (insn[6:0] == 7'h67 && f3 != 3'd0) e.exc = 3'd1;
        else begin
          e.dst = insn[11:7]; e.we = 1'b0; e.alu = 4'd1; e.in0 = pc; e.in1 = 32'd4;
          e.bt = 1'b1; e.bf = 1'b1;
          e.bra = (insn[6:0] == 7'h6F) ? pc + ij : (a + ii) - ((a + ii) % 2);
        end
      end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.exc = 3'd1;
        else begin
          e.bra = pc + ib; e.bf = 1'b1;
          case (f3)
            3'd0: e.bt = (a == b);
            3'd1: e.bt = (a != b);
            3'd4: e.bt = ($signed(a) < $signed(b));
            3'd5: e.bt = !($signed(a) < $signed(b));
            3'd6: e.bt = (a < b);
            default: e.bt = !(a < b);
          endcase
        end
      end
      7'h03: begin
        if (f3 == 3'd3 || f3 > 3'd5) e.exc = 3'd1;
        else begin
          e.dst = insn[11:7]; e.we = 1'b0; e.alu = 4'd1; e.in0 = a; e.in1 = ii;
          e.mem = (f3 < 3'd3) ? 4'(f3) + 4'd1 : 4'(f3);
        end
      end
      7'h23: begin
        if (f3 > 3'd2) e.exc = 3'd1;
        else begin
          e.alu = 4'd1; e.in0 = a; e.in1 = is_; e.gd = b; e.mem = 4'(f3) + 4'd6;
        end
      end
      7'h73: begin
        if (insn == 32'h00000073)      begin e.ctrl = 2'd1; e.exc = 3'd2; end
        else if (insn == 32'h00100073) begin e.ctrl = 2'd2; e.exc = 3'd3; end
        else e.exc = 3'd1;
      end
      7'h0F: begin
        if (f3 == 3'd0) e.ctrl = 2'd3;
        else e.exc = 3'd1;
      end
      default: e.exc = 3'd1;
    endcase
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check($sformatf("%s dst_addr", tag), 32'(dst_addr), 32'(e.dst));
    check($sformatf("%s gpr_we_", tag),  32'(gpr_we_),  32'(e.we));
    check($sformatf("%s alu_op", tag),   32'(alu_op),   32'(e.alu));
    check($sformatf("%s alu_in_0", tag), alu_in_0,      e.in0);
    check($sformatf("%s alu_in_1", tag), alu_in_1,      e.in1);
    check($sformatf("%s br_addr", tag),  br_addr,       e.bra);
    check($sformatf("%s br_taken", tag), 32'(br_taken), 32'(e.bt));
    check($sformatf("%s br_flag", tag),  32'(br_flag),  32'(e.bf));
    check($sformatf("%s mem_op", tag),   32'(mem_op),   32'(e.mem));
    check($sformatf("%s gpr_data", tag), gpr_data,      e.gd);
    check($sformatf("%s ctrl_op", tag),  32'(ctrl_op),  32'(e.ctrl));
    check($sformatf("%s exp_code", tag), 32'(exp_code), 32'(e.exc));
  endtask

  task automatic check_reads(input string tag);
    check($sformatf("%s rd_addr_0", tag), 32'(gpr_rd_addr_0), 32'(if_insn[19:15]));
    check($sformatf("%s rd_addr_1", tag), 32'(gpr_rd_addr_1), 32'(if_insn[24:20]));
    check($sformatf("%s rd_data_0", tag), gpr_rd_data_0, rm[if_insn[19:15]]);
    check($sformatf("%s rd_data_1", tag), gpr_rd_data_1, rm[if_insn[24:20]]);
  endtask

  task automatic read2(input logic [4:0] ra, input logic [4:0] rb);
    if_insn = {7'd0, rb, ra, 3'd0, 5'd0, 7'd0};
    #1;
  endtask

  task automatic wr(input logic n_we, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we_ = n_we; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    we_ = 1'b1;
    if (!n_we && a != 5'd0) rm[a] = d;
  endtask

  initial begin
    logic [6:0]  opcs [11];
    logic [31:0] r;
    logic [6:0]  opc;
    opcs = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73, 7'h0F};

    vecs[0]  = mkv(32'hF0168093, 32'd0,   5'd1, 1'b0, 4'd1,  32'd13, 32'hFFFFFF01, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[1]  = mkv(32'h40F6D093, 32'd0,   5'd1, 1'b0, 4'd10, 32'd13, 32'd15,  32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[2]  = mkv(32'h01F680B3, 32'd0,   5'd1, 1'b0, 4'd1,  32'd13, 32'd31,  32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[3]  = mkv(32'h00A000EF, 32'd5,   5'd1, 1'b0, 4'd1,  32'd5,  32'd4,   32'd15,  1'b1, 1'b1, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[4]  = mkv(32'h00B700E7, 32'd5,   5'd1, 1'b0, 4'd1,  32'd5,  32'd4,   32'd24,  1'b1, 1'b1, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[5]  = mkv(32'h078C0F63, 32'd5,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd131, 1'b1, 1'b1, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[6]  = mkv(32'h078C1F63, 32'd5,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd131, 1'b0, 1'b1, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[7]  = mkv(32'h03FC2083, 32'd0,   5'd1, 1'b0, 4'd1,  32'd24, 32'd63,  32'd0,   1'b0, 1'b0, 4'd3, 32'd0,  2'd0, 3'd0);
    vecs[8]  = mkv(32'h01F420A3, 32'd0,   5'd0, 1'b1, 4'd1,  32'd8,  32'd1,   32'd0,   1'b0, 1'b0, 4'd8, 32'd31, 2'd0, 3'd0);
    vecs[9]  = mkv(32'h0000007F, 32'd0,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd1);
    vecs[10] = mkv(32'h00000073, 32'd0,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd1, 3'd2);
    vecs[11] = mkv(32'h00100073, 32'd0,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd2, 3'd3);
    vecs[12] = mkv(32'h0000000F, 32'd0,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd3, 3'd0);
    vecs[13] = mkv(32'h123450B7, 32'd0,   5'd1, 1'b0, 4'd1,  32'd0,  32'h12345000, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 2'd0, 3'd0);
    vecs[14] = mkv(32'h12345097, 32'h100, 5'd1, 1'b0, 4'd1,  32'h100, 32'h12345000, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 2'd0, 3'd0);
    vecs[15] = mkv(32'h40D70133, 32'd0,   5'd2, 1'b0, 4'd2,  32'd14, 32'd13,  32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd0);
    vecs[16] = mkv(32'h078C2F63, 32'd5,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd0,   1'b0, 1'b0, 4'd0, 32'd0,  2'd0, 3'd1);
    vecs[17] = mkv(32'h0020E463, 32'd0,   5'd0, 1'b1, 4'd0,  32'd0,  32'd0,   32'd8,   1'b1, 1'b1, 4'd0, 32'd0,  2'd0, 3'd0);

    for (int i = 0; i < 32; i++) rm[i] = 32'd0;
    reset = 1'b1; we_ = 1'b1; wr_addr = '0; wr_data = '0; if_insn = '0; if_pc = '0;
    #12 reset = 1'b0;

    read2(5'd31, 5'd5);
    check("reset x31", gpr_rd_data_0, 32'd0);
    check("reset x5",  gpr_rd_data_1, 32'd0);

    for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 32'(i));
    read2(5'd0, 5'd31);
    check("x0 after write", gpr_rd_data_0, 32'd0);
    check("x31 after write", gpr_rd_data_1, 32'd31);

    for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 32'hFFFF);
    read2(5'd5, 5'd31);
    check("x5 we_ high", gpr_rd_data_0, 32'd5);
    check("x31 we_ high", gpr_rd_data_1, 32'd31);

    // a write is not visible before its clock edge
    @(negedge clk);
    we_ = 1'b0; wr_addr = 5'd7; wr_data = 32'hAB;
    read2(5'd7, 5'd0);
    check("no bypass x7", gpr_rd_data_0, 32'd7);
    @(posedge clk); #1;
    we_ = 1'b1;
    check("x7 after edge", gpr_rd_data_0, 32'hAB);
    wr(1'b0, 5'd7, 32'd7);

    for (int i = 0; i < 18; i++) begin
      if_insn = vecs[i].insn;
      if_pc   = vecs[i].pc;
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e);
      check_reads($sformatf("vec%0d", i));
    end

    // reset wins over a simultaneous write
    @(negedge clk);
    we_ = 1'b0; wr_addr = 5'd9; wr_data = 32'h55; reset = 1'b1;
    @(posedge clk); #1;
    we_ = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rm[i] = 32'd0;
    read2(5'd9, 5'd31);
    check("reset over write x9", gpr_rd_data_0, 32'd0);
    check("reset clears x31", gpr_rd_data_1, 32'd0);

    for (int i = 0; i < 40; i++)
      wr(1'($urandom_range(0, 3) == 0), 5'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3));

    for (int i = 0; i < 300; i++) begin
      if (i % 4 == 0)
        wr(1'($urandom_range(0, 3) == 0), 5'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 3));
      r   = $urandom;
      opc = ($urandom_range(0, 11) == 11) ? 7'($urandom) : opcs[$urandom_range(0, 10)];
      if_insn = {r[31:7], opc};
      if_pc   = $urandom;
      #1;
      check_all($sformatf("rnd%0d insn=%h", i, if_insn),
                ref_decode(if_insn, if_pc, rm[if_insn[19:15]], rm[if_insn[24:20]]));
      check_reads($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
